// File: rtl/half_sub.sv
// half_sub: three-stage pipelined IEEE-754 binary16 subtractor, c = a - b,
// round-to-nearest-even, one operation per clock, no backpressure.
module half_sub #(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c
);

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned SIG_W  = FRAC_W + 1;   // significand with hidden bit
    localparam int unsigned EXT_W  = SIG_W + 3;    // plus guard/round/sticky
    localparam int unsigned SUM_W  = EXT_W + 1;    // plus carry-out
    localparam int unsigned EWIDE  = 7;            // exponent with headroom

    if (BITS != 16) begin : g_bits_check
        $error("half_sub: BITS must be 16");
    end

    // Stage 1 -> 2 payload: operands ordered so |x| >= |y|
    typedef struct packed {
        logic              special;
        logic [15:0]       spec_val;
        logic              zsign;
        logic              sx;
        logic              sy;
        logic [EXP_W-1:0]  ex;
        logic [EXP_W-1:0]  d;
        logic [SIG_W-1:0]  xs;
        logic [SIG_W-1:0]  ys;
    } s1_t;

    // Stage 2 -> 3 payload: raw sum/difference awaiting normalization
    typedef struct packed {
        logic              special;
        logic [15:0]       spec_val;
        logic              zsign;
        logic              sign;
        logic [EXP_W-1:0]  e;
        logic [SUM_W-1:0]  m;
    } s2_t;

    logic        s1_v_q, s1_v_d;
    s1_t         s1_q, s1_d;
    logic        s2_v_q, s2_v_d;
    s2_t         s2_q, s2_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] c_q, c_d;

    // Leading-zero count of a 14-bit value (14 when all zero)
    function automatic logic [4:0] lzc14(input logic [EXT_W-1:0] v);
        logic [4:0] n;
        n = 5'd14;
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (v[i]) n = 5'(13 - i);
        end
        return n;
    endfunction

    // Stage 1: unpack, negate b, order by magnitude, detect specials
    logic [EXP_W-1:0]  ea, eb, ea_eff, eb_eff;
    logic [FRAC_W-1:0] ma, mb;
    logic              sa, sb_eff, a_nan, b_nan, a_inf, b_inf, a_ge;
    always_comb begin
        ea     = a[14:10];
        eb     = b[14:10];
        ma     = a[9:0];
        mb     = b[9:0];
        sa     = a[15];
        sb_eff = ~b[15];
        ea_eff = (ea == 5'd0) ? 5'd1 : ea;
        eb_eff = (eb == 5'd0) ? 5'd1 : eb;
        a_nan  = (ea == 5'h1F) && (ma != 10'd0);
        b_nan  = (eb == 5'h1F) && (mb != 10'd0);
        a_inf  = (ea == 5'h1F) && (ma == 10'd0);
        b_inf  = (eb == 5'h1F) && (mb == 10'd0);
        a_ge   = (a[14:0] >= b[14:0]);

        s1_d          = '0;
        s1_v_d        = in_valid;
        s1_d.zsign    = sa & sb_eff;
        if (a_ge) begin
            s1_d.sx = sa;
            s1_d.sy = sb_eff;
            s1_d.ex = ea_eff;
            s1_d.d  = ea_eff - eb_eff;
            s1_d.xs = {(ea != 5'd0), ma};
            s1_d.ys = {(eb != 5'd0), mb};
        end else begin
            s1_d.sx = sb_eff;
            s1_d.sy = sa;
            s1_d.ex = eb_eff;
            s1_d.d  = eb_eff - ea_eff;
            s1_d.xs = {(eb != 5'd0), mb};
            s1_d.ys = {(ea != 5'd0), ma};
        end

        if (a_nan || b_nan) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = 16'h7E00;
        end else if (a_inf && b_inf) begin
            // inf - inf: same sign is invalid, opposite signs keep a
            s1_d.special  = 1'b1;
            s1_d.spec_val = (a[15] == b[15]) ? 16'h7E00 : a;
        end else if (a_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = a;
        end else if (b_inf) begin
            s1_d.special  = 1'b1;
            s1_d.spec_val = {~b[15], 15'h7C00};
        end
    end

    // Stage 2: align y with sticky collection, then add or subtract
    logic [EXT_W-1:0] x_ext, y_ext, y_sh, y_al;
    logic             y_lost;
    always_comb begin
        x_ext  = {s1_q.xs, 3'b000};
        y_ext  = {s1_q.ys, 3'b000};
        y_sh   = '0;
        y_lost = 1'b0;
        if (s1_q.d >= 5'd14) begin
            y_al = {13'd0, |s1_q.ys};
        end else begin
            y_sh   = y_ext >> s1_q.d;
            y_lost = |(y_ext & ((14'd1 << s1_q.d) - 14'd1));
            y_al   = {y_sh[EXT_W-1:1], y_sh[0] | y_lost};
        end

        s2_v_d        = s1_v_q;
        s2_d          = '0;
        s2_d.special  = s1_q.special;
        s2_d.spec_val = s1_q.spec_val;
        s2_d.zsign    = s1_q.zsign;
        s2_d.sign     = s1_q.sx;
        s2_d.e        = s1_q.ex;
        if (s1_q.sx == s1_q.sy) begin
            s2_d.m = {1'b0, x_ext} + {1'b0, y_al};
        end else begin
            s2_d.m = {1'b0, x_ext} - {1'b0, y_al};
        end
    end

    // Stage 3: normalize, round to nearest even, pack and apply overrides
    logic [EWIDE-1:0] e7;
    logic [EXT_W-1:0] n;
    logic [4:0]       lz, em1, sh;
    logic [SIG_W-1:0] mant, mant_f;
    logic [SIG_W:0]   mr;
    logic             g, rs, up;
    logic [15:0]      res;
    always_comb begin
        e7     = EWIDE'(s2_q.e);
        n      = '0;
        lz     = '0;
        em1    = '0;
        sh     = '0;
        mant   = '0;
        mant_f = '0;
        mr     = '0;
        g      = 1'b0;
        rs     = 1'b0;
        up     = 1'b0;
        res    = '0;
        if (s2_q.special) begin
            res = s2_q.spec_val;
        end else if (s2_q.m == '0) begin
            res = {s2_q.zsign, 15'd0};
        end else begin
            if (s2_q.m[SUM_W-1]) begin
                n  = {s2_q.m[14:2], s2_q.m[1] | s2_q.m[0]};
                e7 = e7 + 7'd1;
            end else begin
                // Left shift bounded so the exponent never drops below 1
                lz  = lzc14(s2_q.m[EXT_W-1:0]);
                em1 = 5'(s2_q.e) - 5'd1;
                sh  = (lz < em1) ? lz : em1;
                n   = s2_q.m[EXT_W-1:0] << sh;
                e7  = e7 - EWIDE'(sh);
            end
            mant = n[13:3];
            g    = n[2];
            rs   = n[1] | n[0];
            up   = g & (rs | mant[0]);
            mr   = {1'b0, mant} + {11'd0, up};
            if (mr[SIG_W]) begin
                mant_f = mr[SIG_W:1];
                e7     = e7 + 7'd1;
            end else begin
                mant_f = mr[SIG_W-1:0];
            end
            if (e7 >= 7'd31) begin
                res = {s2_q.sign, 15'h7C00};
            end else begin
                // Hidden bit clear means the result stayed subnormal
                res = {s2_q.sign, (mant_f[10] ? e7[4:0] : 5'd0), mant_f[9:0]};
            end
        end

        out_valid_d = s2_v_q;
        c_d         = s2_v_q ? res : c_q;
    end

    // Pipeline and output registers; reset discards all in-flight ops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_q      <= 1'b0;
            s1_q        <= '0;
            s2_v_q      <= 1'b0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_q        <= s1_d;
            s2_v_q      <= s2_v_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = BITS'(c_q);

endmodule
